irq_arbiter: RTL and testbench

Memory-mapped interrupt controller between the interrupt sources (timers, external device lines) and the CPU's `HWInt` inputs to CP0. It latches or samples up to `NSRC` requests, applies a per-source mask and edge/level mode, and picks one winner by fixed priority. It then drives exactly one `hwint` bit and holds it until the handler acknowledges through a bus write. The CPU configures and services it through the data-port bridge like any other peripheral.

---
 rtl/irq_arbiter.sv | 74 +++++++
 tb/tb_irq_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// irq_arbiter: memory-mapped fixed-priority interrupt controller driving one-hot CP0 HWInt.
module irq_arbiter #(
    parameter int          NSRC      = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hwint
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t state, state_d;
    logic [NSRC-1:0] mask, mode, pend_lat, prev, eff_pend, cand, w1c, ack_clr, hwint_d;
    logic [7:0] cand8;
    logic [2:0] cur_id, win_id, id_d;
    logic hit, wr, ack, unused_bits;
    assign hit         = addr[31:4] == BASE_ADDR[31:4];
    assign wr          = we && hit;
    assign eff_pend    = (mode & pend_lat) | (~mode & src);
    assign cand        = eff_pend & mask;
    assign cand8       = 8'(cand);
    assign ack         = wr && addr[3:2] == 2'd3 && state == REQ && wdata[2:0] == cur_id;
    assign w1c         = (wr && addr[3:2] == 2'd2) ? wdata[NSRC-1:0] & mode : '0;
    assign ack_clr     = ack ? mode & (NSRC'(1) << cur_id) : '0;
    assign unused_bits = ^{addr[1:0], wdata};
    assign rdata = !hit              ? '0 :
                   addr[3:2] == 2'd0 ? 32'(mask) :
                   addr[3:2] == 2'd1 ? 32'(mode) :
                   addr[3:2] == 2'd2 ? 32'(eff_pend) :
                                       {state == REQ, 28'b0, cur_id};
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (cand[i]) win_id = 3'(i);
    end
    // A new edge in the same cycle as a clear wins, so the OR of set comes last.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask     <= '0;
            mode     <= '0;
            pend_lat <= '0;
            prev     <= '0;
        end else begin
            if (wr && addr[3:2] == 2'd0) mask <= wdata[NSRC-1:0];
            if (wr && addr[3:2] == 2'd1) mode <= wdata[NSRC-1:0];
            pend_lat <= (pend_lat & ~(w1c | ack_clr)) | (mode & src & ~prev);
            prev     <= src;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cur_id <= '0;
            hwint  <= '0;
        end else begin
            state  <= state_d;
            cur_id <= id_d;
            hwint  <= hwint_d;
        end
    end
    always_comb begin
        state_d = state == IDLE ? (|cand ? REQ : IDLE) :
                  state == REQ  ? ((ack || !cand8[cur_id]) ? GAP : REQ) :
                                  IDLE;
    end
    always_comb begin
        id_d    = (state == IDLE && |cand) ? win_id : cur_id;
        hwint_d = state_d == REQ ? NSRC'(1) << id_d : '0;
    end
endmodule

// File: tb/tb_irq_arbiter.sv
// tb_irq_arbiter: directed and random checks of irq_arbiter against a cycle-level reference model.
module tb_irq_arbiter;
    localparam int          NSRC = 6;
    localparam logic [31:0] BASE = 32'h0000_7F20;
    logic            clk = 1'b0, reset = 1'b1, we = 1'b0;
    logic [NSRC-1:0] src = '0;
    logic [31:0]     addr = BASE, wdata = '0;
    logic [31:0]     rdata;
    logic [NSRC-1:0] hwint;
    int total = 0, bad = 0;
    bit [NSRC-1:0] m_mask, m_mode, m_pl, m_prev;
    int m_phase, m_cur;

    always #5 clk = ~clk;

    irq_arbiter #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .src(src), .addr(addr), .we(we),
        .wdata(wdata), .rdata(rdata), .hwint(hwint)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        logic [31:0] r = '0;
        if (a[31:4] != BASE[31:4]) return '0;
        case (a[3:2])
            2'd0: r = 32'(m_mask);
            2'd1: r = 32'(m_mode);
            2'd2: for (int i = 0; i < NSRC; i++) r[i] = m_mode[i] ? m_pl[i] : src[i];
            default: r = {m_phase == 1, 28'b0, 3'(m_cur)};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] m_hw();
        return m_phase == 1 ? 32'(1) << m_cur : 32'(0);
    endfunction

    // Phases: 0 idle, 1 granted, 2 one-cycle gap.
    task automatic m_step();
        bit [NSRC-1:0] cand;
        bit hit, ack;
        int w;
        if (reset) begin
            m_mask = '0; m_mode = '0; m_pl = '0; m_prev = '0;
            m_phase = 0; m_cur = 0;
            return;
        end
        hit = addr[31:4] == BASE[31:4];
        for (int i = 0; i < NSRC; i++) cand[i] = m_mask[i] && (m_mode[i] ? m_pl[i] : src[i]);
        ack = hit && we && addr[3:2] == 2'd3 && m_phase == 1 && wdata[2:0] == 3'(m_cur);
        if (m_phase == 0) begin
            w = -1;
            for (int i = 0; i < NSRC; i++) if (cand[i] && w < 0) w = i;
            if (w >= 0) begin m_cur = w; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (ack || !cand[m_cur]) m_phase = 2;
        end else m_phase = 0;
        for (int i = 0; i < NSRC; i++) begin
            if (m_mode[i] && ((hit && we && addr[3:2] == 2'd2 && wdata[i]) || (ack && i == m_cur))) m_pl[i] = 1'b0;
            if (m_mode[i] && src[i] && !m_prev[i]) m_pl[i] = 1'b1;
        end
        if (hit && we && addr[3:2] == 2'd0) m_mask = wdata[NSRC-1:0];
        if (hit && we && addr[3:2] == 2'd1) m_mode = wdata[NSRC-1:0];
        m_prev = src;
    endtask

    task automatic tick();
        #1 chk("rdata", rdata, m_rd(addr));
        m_step();
        @(posedge clk);
        #1 chk("hwint", 32'(hwint), m_hw());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0; wdata = '0;
    endtask

    task automatic rdc(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; we = 1'b0;
        #1 chk(tag, rdata, exp);
    endtask

    initial begin
        int op;
        tick(); tick();
        reset = 1'b0;
        rdc("rst_mask", BASE, 0); rdc("rst_mode", BASE + 4, 0);
        rdc("rst_pend", BASE + 8, 0); rdc("rst_stat", BASE + 12, 0);
        chk("rst_hw", 32'(hwint), 0);
        src = 6'b000100; tick(); src = '0;
        chk("masked_hw", 32'(hwint), 0);
        rdc("lvl_pend", BASE + 8, 0);
        // Edge source 2: latch at k, grant after k+1, ack, no regrant.
        wr(BASE, 32'h3F); wr(BASE + 4, 32'h04);
        src = 6'b000100; tick(); src = '0;
        chk("edge_k", 32'(hwint), 0);
        tick();
        chk("edge_k1", 32'(hwint), 32'h04);
        rdc("edge_stat", BASE + 12, 32'h8000_0002);
        wr(BASE + 12, 2);
        chk("edge_ack", 32'(hwint), 0);
        rdc("edge_pend", BASE + 8, 0);
        repeat (4) tick();
        chk("no_regrant", 32'(hwint), 0);
        // Level sources 0 and 3.
        wr(BASE + 4, 0); wr(BASE, 32'h09);
        src = 6'b001001; tick();
        chk("lvl_g0", 32'(hwint), 32'h01);
        wr(BASE + 12, 0);
        chk("lvl_ack0", 32'(hwint), 0);
        tick(); tick();
        chk("lvl_regrant0", 32'(hwint), 32'h01);
        src = 6'b001000;
        repeat (3) tick();
        chk("lvl_g3", 32'(hwint), 32'h08);
        // Wrong-id ack ignored, then mask drop abandons.
        src = '0; tick(); tick();
        wr(BASE, 32'h3F);
        src = 6'b000010; tick();
        chk("g1", 32'(hwint), 32'h02);
        wr(BASE + 12, 3);
        chk("bad_ack", 32'(hwint), 32'h02);
        wr(BASE, 32'h3D);
        chk("mask_wr_edge", 32'(hwint), 32'h02);
        tick();
        chk("mask_drop", 32'(hwint), 0);
        tick();
        // Set beats same-cycle W1C on edge source 4.
        src = '0; wr(BASE + 4, 32'h10); tick();
        src = 6'b010000; tick(); src = '0; tick();
        chk("g4", 32'(hwint), 32'h10);
        src = 6'b010000; wr(BASE + 8, 32'h10);
        rdc("set_beats_clr", BASE + 8, m_rd(BASE + 8));
        chk("pend4", rdata & 32'h10, 32'h10);
        chk("g4_hold", 32'(hwint), 32'h10);
        // Reset mid-REQ, then an out-of-window access.
        reset = 1'b1; tick(); reset = 1'b0; src = '0;
        chk("rst_req_hw", 32'(hwint), 0);
        rdc("rst2_mask", BASE, 0); rdc("rst2_mode", BASE + 4, 0);
        rdc("rst2_stat", BASE + 12, 0);
        wr(32'h7F30, 32'hFFFF_FFFF);
        rdc("miss_rd", 32'h7F30, 0); rdc("miss_mask", BASE, 0); rdc("miss_mode", BASE + 4, 0);
        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = $urandom_range(0, 499) == 0;
            for (int i = 0; i < NSRC; i++) if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
            op = $urandom_range(0, 9);
            we = op >= 5;
            wdata = $urandom;
            case (op)
                5: addr = BASE;
                6: addr = BASE + 4;
                7: addr = BASE + 8;
                8, 9: begin
                    addr = BASE + 12;
                    if ($urandom_range(0, 9) < 7) wdata = 32'(m_cur);
                end
                default: addr = $urandom_range(0, 5) == 0 ? 32'h7F30 : BASE + 32'(4 * $urandom_range(0, 3));
            endcase
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
